ps2_scan_history: RTL and testbench
===================================

# ps2_scan_history

Parametrised PS/2 keyboard receiver with scan-code decoding and history buffering. It deserialises PS/2 device-to-host frames and checks them. It folds `E0` (extended) and `F0` (break) prefixes into tagged 10-bit key codes and queues those codes in a `DEPTH`-entry FIFO for a consumer. It also drives the board's six HEX displays and ten LEDs with the three most recent codes and status. It sits directly under `top`, replacing the fixed single-byte keyboard display.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `TIMEOUT_CYCLES`, 50000: idle clocks inside a frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
- `CLOCK_50` in 1: sole clock, 50 MHz.
- `resetn` in 1: asynchronous, active-low reset, driven from `KEY[0]`.
- `PS2_CLK` in 1: PS/2 clock, asynchronous to `CLOCK_50`.
- `PS2_DAT` in 1: PS/2 data, asynchronous to `CLOCK_50`.
- `rd_en` in 1: consumer pop request.
- `code_valid` out 1: FIFO non-empty; `code_out` holds the head entry.
- `code_out` out 10: head entry as {ext, brk, byte[7:0]}.
- `LEDR` out 10: status.
- `HEX0`..`HEX5` out 7 each: active-low segments {g,f,e,d,c,b,a}.

## Operation

- **Input sync:** `PS2_CLK` and `PS2_DAT` each pass through a 2-FF synchroniser. A falling edge is a registered synced clock going 1 to 0. Data is sampled on the edge cycle.
- **Receiver FSM, IDLE:** on a falling edge with data 0 (start bit), go to SHIFT with bit count 0. A falling edge with data 1 is ignored.
- **Receiver FSM, SHIFT:**
  - The next 10 edges capture data[0..7] LSB-first, then parity, then stop.
  - After the stop edge, go to CHECK.
  - If no edge arrives for `TIMEOUT_CYCLES` consecutive clocks, go to IDLE, discard the frame and flag a frame error.
- **Receiver FSM, CHECK (1 cycle):** the frame is valid iff data plus parity has an odd number of ones and stop = 1.
  - Valid: pulse `byte_valid` internally for one cycle.
  - Invalid: discard and flag a frame error.
  - Always return to IDLE.
- **Decoder:**
  - Byte `E0` sets `ext` and pushes nothing.
  - Byte `F0` sets `brk` and pushes nothing.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - Repeated prefixes are harmless; the flags are idempotent.
- **FIFO:** `DEPTH` entries, first-word fall-through.
  - A pop occurs when `rd_en & code_valid`; `rd_en` while empty is ignored.
  - Push while full without a simultaneous pop: the code is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: the push succeeds only.
  - Pointers wrap modulo `DEPTH`. The count is `log2(DEPTH)+1` bits wide.
- **History:** a 3-deep shift register of pushed codes, updated on every accepted push. Dropped codes also update it.
  - HEX1:HEX0 show the newest byte.
  - HEX3:HEX2 show the previous byte.
  - HEX5:HEX4 show the oldest byte.
  - Glyphs are standard 0-F. A slot never written stays blank (`7'h7F`).
- **LEDR:**
  - [0]: ext of the newest code.
  - [1]: brk of the newest code.
  - [2]: FIFO full.
  - [3]: overflow (sticky).
  - [4]: frame error (sticky).
  - [9:5]: FIFO count, saturated at 31.
- **Clearing sticky flags:** only reset clears them.

## Timing

- **Reset values:**
  - `code_valid` = 0, `code_out` = 0, `LEDR` = 0.
  - All HEX outputs = `7'h7F`.
  - FSM in IDLE; flags, pointers and history cleared.
- **Reset mid-operation:** takes effect immediately; any partial frame is lost. After release, the receiver rearms at the next start bit.
- **Latency:** let t be the cycle in which the stop bit's falling edge is detected.
  - CHECK at t+1.
  - FIFO and history write at t+2.
  - `code_valid`, `code_out`, HEX and LEDR update at t+3.
- **Pop:** on the cycle after a pop, `code_out` shows the next entry, or `code_valid` = 0 if the FIFO is now empty.
- **Asynchronous timing:** total PS/2 input-to-edge-detect delay is 3 clocks. PS/2 clock periods of 60-100 µs are far above the minimum edge spacing the design needs (3 clocks).

## Test plan

- **Make/break:** send frames `1C`, `F0`, `1C`. Expect two pushes: `0x01C` then `0x11C`. HEX1:HEX0 = "1C", HEX3:HEX2 = "1C", LEDR[1] = 1.
- **Extended break:** send `E0`, `F0`, `75`. Expect a single push `0x375`. LEDR[0] = 1 and LEDR[1] = 1.
- **Bad parity:** send byte `29` with even parity. Expect no push and LEDR[4] = 1. A following good frame `29` pushes `0x029`.
- **Truncated frame:** send start bit plus 4 bits, then hold the clock high for `TIMEOUT_CYCLES` + 2. Expect the FSM back in IDLE and LEDR[4] = 1. A following frame `16` is received correctly.
- **Overflow with `DEPTH` = 4:** send 5 codes with `rd_en` = 0. Expect count 4, LEDR[2] = 1, LEDR[3] = 1, and the head still code #1. Then pop 4 times: codes #1-#4 appear in order and `code_valid` ends at 0.
- **Full FIFO, simultaneous push and pop:** with the FIFO full, hold `rd_en` = 1 in the push cycle. Expect both to succeed, count to stay 4 and no overflow.

Source files
------------

// File: rtl/ps2_scan_history_if.sv
// Consumer-side port bundle for the decoded key-code queue.
// Handshake: code_valid is high whenever code_out holds a queued entry;
// the consumer raises rd_en to take it, and an entry is removed only in a
// cycle where rd_en and code_valid are both high. rd_en while code_valid is
// low has no effect, and code_out is held stable until the entry is taken.
interface ps2_scan_history_if;
  logic       rd_en;
  logic       code_valid;
  logic [9:0] code_out;

  // Side that owns the queue.
  modport master (input rd_en, output code_valid, output code_out);
  // Side that consumes codes.
  modport slave (output rd_en, input code_valid, input code_out);
endinterface

// File: rtl/ps2_scan_history.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises and
// checks device-to-host frames, folds E0/F0 prefixes into tagged 10-bit
// codes {ext, brk, byte}, queues them in a first-word fall-through FIFO and
// shows the last three codes plus status on the HEX displays and LEDs.
module ps2_scan_history #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      PS2_CLK,
  input  logic                      PS2_DAT,
  ps2_scan_history_if.master        code_if,
  output logic [9:0]                LEDR,
  output logic [6:0]                HEX0,
  output logic [6:0]                HEX1,
  output logic [6:0]                HEX2,
  output logic [6:0]                HEX3,
  output logic [6:0]                HEX4,
  output logic [6:0]                HEX5,
  output logic [1:0]                dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

  // Synchroniser and edge-detect registers; idle PS/2 lines are high, so
  // resetting to 1 avoids a spurious falling edge after reset release.
  logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic fall;

  // Two-stage synchronisers plus a delayed copy of the synced clock.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_d & ~clk_s2;

  rx_state_t     state;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;      // {stop, parity, data[7:0]} after ten edges
  logic [TW-1:0] idle_cnt;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_err;

  // Frame receiver: start detect, ten-bit shift with idle timeout, check.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall && !dat_s2) begin
            state    <= ST_SHIFT;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (fall) begin
            shreg    <= {dat_s2, shreg[9:1]};
            idle_cnt <= '0;
            if (bit_cnt == 4'd9) state <= ST_CHECK;
            else                 bit_cnt <= bit_cnt + 4'd1;
          end else if (idle_cnt == TO_LAST) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          // Odd parity over data+parity and a high stop bit.
          if ((^shreg[8:0]) && shreg[9]) begin
            byte_valid <= 1'b1;
            rx_byte    <= shreg[7:0];
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  logic          ext_f, brk_f;
  logic          push, pop, full, wr_ok;
  logic [9:0]    new_code;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [9:0]    mem [DEPTH];
  logic [9:0]    h0;
  logic [7:0]    h1, h2;
  logic [2:0]    hv;

  assign push     = byte_valid && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
  assign new_code = {ext_f, brk_f, rx_byte};
  assign pop      = code_if.rd_en && (count != '0);
  assign full     = (count == DEPTH_C);
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign wr_ok    = push && (!full || pop);

  // Prefix decoder, FIFO pointers/count, sticky overflow and display history.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      h0       <= '0;
      h1       <= '0;
      h2       <= '0;
      hv       <= '0;
    end else begin
      if (byte_valid) begin
        if (rx_byte == 8'hE0)      ext_f <= 1'b1;
        else if (rx_byte == 8'hF0) brk_f <= 1'b1;
        else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (!wr_ok && pop) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      // History follows every decoded code, including ones the FIFO dropped.
      if (push) begin
        h2 <= h1;
        h1 <= h0[7:0];
        h0 <= new_code;
        hv <= {hv[1:0], 1'b1};
      end
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) mem[wr_ptr] <= new_code;
  end

  assign code_if.code_valid = (count != '0);
  assign code_if.code_out   = (count != '0) ? mem[rd_ptr] : 10'h000;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [8:0] count_w;
  logic [4:0] count_sat;

  // Status LEDs and displays; unwritten history slots stay blank.
  always_comb begin
    count_w   = 9'(count);
    count_sat = (count_w > 9'd31) ? 5'd31 : count_w[4:0];
    LEDR      = {count_sat, frame_err, overflow, full, h0[8], h0[9]};
    HEX0      = hv[0] ? seg7(h0[3:0]) : 7'h7F;
    HEX1      = hv[0] ? seg7(h0[7:4]) : 7'h7F;
    HEX2      = hv[1] ? seg7(h1[3:0]) : 7'h7F;
    HEX3      = hv[1] ? seg7(h1[7:4]) : 7'h7F;
    HEX4      = hv[2] ? seg7(h2[3:0]) : 7'h7F;
    HEX5      = hv[2] ? seg7(h2[7:4]) : 7'h7F;
  end

endmodule

// File: tb/tb_ps2_scan_history.sv
// Directed bench for ps2_scan_history: a vector table of frames with
// hand-computed status/display expectations, plus hand-written sequences
// for reset mid-frame, timeout, overflow and full push+pop.
module tb_ps2_scan_history;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 5;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0] dbg_state;

  ps2_scan_history_if cif ();
  assign cif.rd_en = rd_en;

  ps2_scan_history #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .code_if  (cif),
    .LEDR     (ledr),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5),
    .dbg_state(dbg_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       bad;
    logic       push;
    logic [9:0] code;
    logic [9:0] led;
    int         nw;
    int         pv;
    int         od;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // {high glyph, low glyph} for a byte, or blank for -1.
  function automatic logic [13:0] pair(input int b);
    logic [7:0] v;
    if (b < 0) return {7'h7F, 7'h7F};
    v = b[7:0];
    return {seg(v[7:4]), seg(v[3:0])};
  endfunction

  task automatic chk_hist(input string tag, input int nw, input int pv, input int od);
    chk({tag, "_hex10"}, {18'h0, hex1, hex0}, {18'h0, pair(nw)});
    chk({tag, "_hex32"}, {18'h0, hex3, hex2}, {18'h0, pair(pv)});
    chk({tag, "_hex54"}, {18'h0, hex5, hex4}, {18'h0, pair(od)});
  endtask

  // Drive one device-to-host frame; with hold_low the stop-bit clock is
  // left low and the caller finishes the bit.
  task automatic send_frame(input logic [7:0] data, input logic bad, input logic hold_low);
    logic [10:0] bits;
    bits = {1'b1, ~(^data) ^ bad, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (hold_low && i == 10) return;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  // Start bit plus four data bits, then the clock idles high.
  task automatic send_partial();
    logic [4:0] bits;
    bits = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (6) @(negedge clk);
  endtask

  // Pop everything, comparing against the expected queue in order.
  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 2 && cif.code_valid; k++) begin
      if (exp_q.size() == 0) chk({tag, "_unexpected_entry"}, {31'h0, cif.code_valid}, 32'h0);
      else chk({tag, "_code"}, {22'h0, cif.code_out}, {22'h0, exp_q.pop_front()});
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    chk({tag, "_empty_valid"}, {31'h0, cif.code_valid}, 32'h0);
    chk({tag, "_missing_entries"}, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic found;
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 10'h020, 'h1C, -1, -1};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 10'h000, 'h1C, -1, -1};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 10'h11C, 10'h022, 'h1C, 'h1C, -1};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 10'h002, 'h1C, 'h1C, -1};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 10'h002, 'h1C, 'h1C, -1};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 10'h375, 10'h023, 'h75, 'h1C, 'h1C};
    vecs[6]  = '{8'h29, 1'b1, 1'b0, 10'h000, 10'h013, 'h75, 'h1C, 'h1C};
    vecs[7]  = '{8'h29, 1'b0, 1'b1, 10'h029, 10'h030, 'h29, 'h75, 'h1C};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 10'h010, 'h29, 'h75, 'h1C};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 10'h010, 'h29, 'h75, 'h1C};
    vecs[10] = '{8'h5A, 1'b0, 1'b1, 10'h25A, 10'h031, 'h5A, 'h29, 'h75};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_code_valid", {31'h0, cif.code_valid}, 32'h0);
    chk("rst_code_out", {22'h0, cif.code_out}, 32'h0);
    chk("rst_ledr", {22'h0, ledr}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
    chk_hist("rst", -1, -1, -1);
    resetn = 1'b1;
    @(negedge clk);

    // Table: make/break, extended break, bad parity, repeated prefixes.
    for (int v = 0; v < 11; v++) begin
      send_frame(vecs[v].data, vecs[v].bad, 1'b0);
      if (vecs[v].push) exp_q.push_back(vecs[v].code);
      chk($sformatf("vec%0d_ledr", v), {22'h0, ledr}, {22'h0, vecs[v].led});
      chk_hist($sformatf("vec%0d", v), vecs[v].nw, vecs[v].pv, vecs[v].od);
      drain($sformatf("vec%0d_drain", v));
    end

    // Reset in the middle of a frame.
    send_partial();
    chk("midrst_in_shift", {30'h0, dbg_state}, {30'h0, S_SHIFT});
    resetn = 1'b0;
    #1;
    chk("midrst_state_now", {30'h0, dbg_state}, {30'h0, S_IDLE});
    repeat (2) @(negedge clk);
    chk("midrst_ledr", {22'h0, ledr}, 32'h0);
    chk_hist("midrst", -1, -1, -1);
    resetn = 1'b1;
    @(negedge clk);

    // Truncated frame abandoned by the idle timeout, then a good frame.
    send_partial();
    chk("trunc_in_shift", {30'h0, dbg_state}, {30'h0, S_SHIFT});
    repeat (TIMEOUT + 2) @(negedge clk);
    chk("trunc_state_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});
    chk("trunc_ledr", {22'h0, ledr}, 32'h010);
    send_frame(8'h16, 1'b0, 1'b0);
    exp_q.push_back(10'h016);
    chk("after_trunc_ledr", {22'h0, ledr}, 32'h030);
    chk_hist("after_trunc", 'h16, -1, -1);
    drain("after_trunc_drain");

    // Overflow: five codes into a four-entry FIFO with no reads.
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    chk("ovf_ledr", {22'h0, ledr}, 32'h08C);
    chk("ovf_head", {22'h0, cif.code_out}, 32'h011);
    chk_hist("ovf", 'h55, 'h44, 'h33);
    exp_q = '{10'h011, 10'h022, 10'h033, 10'h044};
    drain("ovf_drain");
    chk("ovf_sticky_ledr", {22'h0, ledr}, 32'h008);

    // Full FIFO with a pop in the push cycle.
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);
    chk("full_ledr", {22'h0, ledr}, 32'h084);
    send_frame(8'h66, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (dbg_state == S_CHECK) found = 1'b1;
    end
    chk("full_check_seen", {31'h0, found}, 32'h1);
    @(negedge clk);
    chk("full_before_write_hex10", {18'h0, hex1, hex0}, {18'h0, pair('h44)});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("full_after_write_hex10", {18'h0, hex1, hex0}, {18'h0, pair('h66)});
    chk("full_pushpop_ledr", {22'h0, ledr}, 32'h084);
    chk("full_pushpop_head", {22'h0, cif.code_out}, 32'h022);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
    chk_hist("full", 'h66, 'h44, 'h33);
    exp_q = '{10'h022, 10'h033, 10'h044, 10'h066};
    drain("full_drain");
    chk("full_end_ledr", {22'h0, ledr}, 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
